// File: rtl/alu_decode_pipe_pkg.sv
// Shared decode definitions: ALU function codes, major opcodes (instr[6:2])
// and bit positions of the one-hot mul/div operation vector.
package alu_decode_pipe_pkg;

  typedef enum logic [3:0] {
    RV_ALU_NONE = 4'd0,
    RV_ALU_ADD  = 4'd1,
    RV_ALU_SUB  = 4'd2,
    RV_ALU_AND  = 4'd3,
    RV_ALU_OR   = 4'd4,
    RV_ALU_XOR  = 4'd5,
    RV_ALU_SLL  = 4'd6,
    RV_ALU_SRL  = 4'd7,
    RV_ALU_SRA  = 4'd8,
    RV_ALU_SLT  = 4'd9,
    RV_ALU_SLTU = 4'd10
  } rv_alu_e;

  localparam logic [4:0] OPC_LOAD      = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
  localparam logic [4:0] OPC_AUIPC     = 5'b00101;
  localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
  localparam logic [4:0] OPC_STORE     = 5'b01000;
  localparam logic [4:0] OPC_OP        = 5'b01100;
  localparam logic [4:0] OPC_LUI       = 5'b01101;
  localparam logic [4:0] OPC_OP_32     = 5'b01110;
  localparam logic [4:0] OPC_BRANCH    = 5'b11000;
  localparam logic [4:0] OPC_JALR      = 5'b11001;
  localparam logic [4:0] OPC_JAL       = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

  localparam int unsigned MD_MUL    = 0;
  localparam int unsigned MD_MULH   = 1;
  localparam int unsigned MD_MULHSU = 2;
  localparam int unsigned MD_MULHU  = 3;
  localparam int unsigned MD_DIV    = 4;
  localparam int unsigned MD_DIVU   = 5;
  localparam int unsigned MD_REM    = 6;
  localparam int unsigned MD_REMU   = 7;

  // alt picks SUB for funct3=000 and SRA for funct3=101; caller qualifies it.
  function automatic rv_alu_e alu_func_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? RV_ALU_SUB : RV_ALU_ADD;
      3'b001:  return RV_ALU_SLL;
      3'b010:  return RV_ALU_SLT;
      3'b011:  return RV_ALU_SLTU;
      3'b100:  return RV_ALU_XOR;
      3'b101:  return alt ? RV_ALU_SRA : RV_ALU_SRL;
      3'b110:  return RV_ALU_OR;
      default: return RV_ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/uriscv_skid_buf.sv
// Two-entry valid/ready buffer: an output register plus one skid register,
// so the upstream ready can be a flop while sustaining one transfer per cycle.
module uriscv_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             r_out_valid;
  logic             r_skid_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid_data;
  logic             w_accept;
  logic             w_out_free;

  assign in_ready_o  = ~r_skid_valid;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign w_accept    = in_valid_i & ~r_skid_valid;
  assign w_out_free  = ~r_out_valid | out_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
      r_out_data   <= '0;
      r_skid_data  <= '0;
    end else if (flush_i) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      // A held skid entry is older than anything upstream, so it moves first.
      if (r_skid_valid) begin
        r_out_data   <= r_skid_data;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_accept;
        if (w_accept) r_out_data <= in_data_i;
      end
    end else if (w_accept) begin
      r_skid_data  <= in_data_i;
      r_skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/alu_decode_pipe.sv
// Registered RV32I/RV64I decode/issue stage: combinational decode into a
// skid-buffered bundle, with mul/div issue held while the mul/div unit is busy.
module alu_decode_pipe
  import alu_decode_pipe_pkg::*;
#(
  parameter int XLEN                     = 32,
  parameter int PC_W                     = 32,
  parameter int SUPPORT_CSR              = 1,
  parameter int SUPPORT_MUL              = 1,
  parameter int SUPPORT_DIV              = 1,
  parameter int SUPPORT_TRAP_INVALID_OPC = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            fetch_valid_i,
  output logic            fetch_ready_o,
  input  logic [31:0]     fetch_instr_i,
  input  logic [PC_W-1:0] fetch_pc_i,
  input  logic [XLEN-1:0] rs1_val_i,
  input  logic [XLEN-1:0] rs2_val_i,
  input  logic [XLEN-1:0] csr_data_i,
  input  logic            muldiv_busy_i,
  output logic            issue_valid_o,
  input  logic            issue_ready_i,
  output logic [PC_W-1:0] pc_o,
  output logic [XLEN-1:0] alu_a_o,
  output logic [XLEN-1:0] alu_b_o,
  output logic [3:0]      alu_func_o,
  output logic            write_rd_o,
  output logic [4:0]      rd_idx_o,
  output logic [7:0]      muldiv_op_o,
  output logic            invalid_o
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      func;
    logic            wr;
    logic [4:0]      rd;
    logic [7:0]      md;
    logic            inv;
  } bundle_t;

  localparam bit L_TRAP = (SUPPORT_TRAP_INVALID_OPC != 0);

  logic [4:0]      w_opc;
  logic [2:0]      w_f3;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_pc_x;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  rv_alu_e         w_func;
  logic            w_wr;
  logic [7:0]      w_md;
  logic            w_illegal;
  bundle_t         w_in;
  bundle_t         w_out;
  logic            w_out_valid;
  logic            w_out_ready;
  logic            w_stall;

  assign w_opc   = fetch_instr_i[6:2];
  assign w_f3    = fetch_instr_i[14:12];
  assign w_imm_i = XLEN'($signed(fetch_instr_i[31:20]));
  assign w_imm_u = XLEN'($signed({fetch_instr_i[31:12], 12'h000}));
  assign w_pc_x  = XLEN'(fetch_pc_i);

  always_comb begin
    w_a       = '0;
    w_b       = '0;
    w_func    = RV_ALU_NONE;
    w_wr      = 1'b0;
    w_md      = '0;
    w_illegal = (fetch_instr_i[1:0] != 2'b11);
    case (w_opc)
      OPC_OP_IMM: begin
        w_a    = rs1_val_i;
        w_b    = w_imm_i;
        w_func = alu_func_f3(w_f3, fetch_instr_i[30] & (w_f3 == 3'b101));
        w_wr   = 1'b1;
      end
      OPC_OP: begin
        w_a = rs1_val_i;
        w_b = rs2_val_i;
        if (fetch_instr_i[31:25] == 7'b0000001) begin
          if (w_f3[2] ? (SUPPORT_DIV != 0) : (SUPPORT_MUL != 0)) begin
            w_md = 8'b1 << w_f3;
            w_wr = 1'b1;
          end else begin
            w_illegal = 1'b1;
          end
        end else begin
          w_func = alu_func_f3(w_f3, fetch_instr_i[30]);
          w_wr   = 1'b1;
        end
      end
      OPC_LUI, OPC_AUIPC: begin
        w_a    = (w_opc == OPC_AUIPC) ? w_pc_x : '0;
        w_b    = w_imm_u;
        w_func = RV_ALU_ADD;
        w_wr   = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        w_a    = w_pc_x;
        w_b    = XLEN'(4);
        w_func = RV_ALU_ADD;
        w_wr   = 1'b1;
      end
      OPC_SYSTEM: begin
        // funct3=000 is ECALL/EBREAK/MRET: no rd write, nothing for the ALU.
        if (w_f3 == 3'b100 || SUPPORT_CSR == 0) begin
          w_illegal = 1'b1;
        end else if (w_f3 != 3'b000) begin
          w_b    = csr_data_i;
          w_func = RV_ALU_ADD;
          w_wr   = 1'b1;
        end
      end
      OPC_LOAD:                             w_wr = 1'b1;
      OPC_STORE, OPC_BRANCH, OPC_MISC_MEM:  ;
      default:                              w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_a    = '0;
      w_b    = '0;
      w_func = RV_ALU_NONE;
      w_wr   = 1'b0;
      w_md   = '0;
    end
  end

  assign w_in = '{pc: fetch_pc_i, a: w_a, b: w_b, func: w_func, wr: w_wr,
                  rd: fetch_instr_i[11:7], md: w_md, inv: L_TRAP & w_illegal};

  uriscv_skid_buf #(
    .WIDTH($bits(bundle_t))
  ) u_skid (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .in_valid_i  (fetch_valid_i),
    .in_ready_o  (fetch_ready_o),
    .in_data_i   (w_in),
    .out_valid_o (w_out_valid),
    .out_ready_i (w_out_ready),
    .out_data_o  (w_out)
  );

  // Only mul/div ops wait on the busy mul/div unit.
  assign w_stall       = (|w_out.md) & muldiv_busy_i;
  assign issue_valid_o = w_out_valid & ~w_stall;
  assign w_out_ready   = issue_ready_i & ~w_stall;

  assign pc_o        = w_out.pc;
  assign alu_a_o     = w_out.a;
  assign alu_b_o     = w_out.b;
  assign alu_func_o  = w_out.func;
  assign write_rd_o  = w_out.wr;
  assign rd_idx_o    = w_out.rd;
  assign muldiv_op_o = w_out.md;
  assign invalid_o   = w_out.inv;

endmodule

// File: tb/tb_alu_decode_pipe.sv
// Bench for alu_decode_pipe: decode vector table, hand-written handshake corners,
// and a randomized run against a queue-based reference model.
module tb_alu_decode_pipe;
  import alu_decode_pipe_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  func;
    logic        wr;
    logic [4:0]  rd;
    logic [7:0]  md;
    logic        inv;
  } bund_t;

  typedef struct packed {
    logic [31:0] instr, pc, rs1, rs2, csr, a, b;
    logic [3:0]  func;
    logic        wr;
    logic [7:0]  md;
    logic        inv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n, flush, fvalid, busy, iready;
  logic [31:0] instr, pc, rs1, rs2, csr;
  logic        frdy[3], ivalid[3], wr[3], inv[3];
  logic [31:0] pco[3], ao[3], bo[3];
  logic [3:0]  fn[3];
  logic [4:0]  rd[3];
  logic [7:0]  md[3];
  int          total = 0;
  int          bad = 0;
  vec_t        tbl[15];
  bund_t       q[$];

  always #5 clk = ~clk;

  // Instance 0: default build; 1: no MUL support; 2: invalid trapping disabled.
  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_dut
    alu_decode_pipe #(
      .SUPPORT_MUL              (gi == 1 ? 0 : 1),
      .SUPPORT_TRAP_INVALID_OPC (gi == 2 ? 0 : 1)
    ) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .fetch_valid_i(fvalid), .fetch_ready_o(frdy[gi]), .fetch_instr_i(instr),
      .fetch_pc_i(pc), .rs1_val_i(rs1), .rs2_val_i(rs2), .csr_data_i(csr),
      .muldiv_busy_i(busy), .issue_valid_o(ivalid[gi]), .issue_ready_i(iready),
      .pc_o(pco[gi]), .alu_a_o(ao[gi]), .alu_b_o(bo[gi]), .alu_func_o(fn[gi]),
      .write_rd_o(wr[gi]), .rd_idx_o(rd[gi]), .muldiv_op_o(md[gi]), .invalid_o(inv[gi])
    );
  end

  function automatic bund_t got(input int k);
    bund_t r;
    r = {pco[k], ao[k], bo[k], fn[k], wr[k], rd[k], md[k], inv[k]};
    return r;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input bund_t act, input bund_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got pc=%h a=%h b=%h f=%0d wr=%b rd=%0d md=%h inv=%b want pc=%h a=%h b=%h f=%0d wr=%b rd=%0d md=%h inv=%b",
               nm, act.pc, act.a, act.b, act.func, act.wr, act.rd, act.md, act.inv,
               exp.pc, exp.a, exp.b, exp.func, exp.wr, exp.rd, exp.md, exp.inv);
    end
  endtask

  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? RV_ALU_SUB : RV_ALU_ADD;
      3'd1:    return RV_ALU_SLL;
      3'd2:    return RV_ALU_SLT;
      3'd3:    return RV_ALU_SLTU;
      3'd4:    return RV_ALU_XOR;
      3'd5:    return alt ? RV_ALU_SRA : RV_ALU_SRL;
      3'd6:    return RV_ALU_OR;
      default: return RV_ALU_AND;
    endcase
  endfunction

  // Reference decode for the default build, keyed on the full 7-bit opcode.
  function automatic bund_t ref_dec(input logic [31:0] ins, pcv, r1, r2, cs);
    bund_t e;
    logic  ill;
    logic [2:0] f3;
    e = '0; e.pc = pcv; e.rd = ins[11:7]; ill = 1'b0; f3 = ins[14:12];
    case (ins[6:0])
      7'h13: begin e.a = r1; e.b = {{20{ins[31]}}, ins[31:20]};
                   e.func = ref_alu(f3, f3 == 3'd5 && ins[30]); e.wr = 1'b1; end
      7'h33: begin e.a = r1; e.b = r2; e.wr = 1'b1;
                   if (ins[31:25] == 7'h01) e.md = 8'(1 << f3);
                   else e.func = ref_alu(f3, ins[30]); end
      7'h37: begin e.b = {ins[31:12], 12'h000}; e.func = RV_ALU_ADD; e.wr = 1'b1; end
      7'h17: begin e.a = pcv; e.b = {ins[31:12], 12'h000}; e.func = RV_ALU_ADD; e.wr = 1'b1; end
      7'h6F, 7'h67: begin e.a = pcv; e.b = 32'd4; e.func = RV_ALU_ADD; e.wr = 1'b1; end
      7'h73: begin
        if (f3 == 3'd4) ill = 1'b1;
        else if (f3 != 3'd0) begin e.b = cs; e.func = RV_ALU_ADD; e.wr = 1'b1; end
      end
      7'h03: e.wr = 1'b1;
      7'h23, 7'h63, 7'h0F: ;
      default: ill = 1'b1;
    endcase
    if (ill) begin
      e.a = '0; e.b = '0; e.func = RV_ALU_NONE; e.wr = 1'b0; e.md = '0; e.inv = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [6:0]  opc;
    r = $urandom();
    case ($urandom_range(0, 15))
      0: opc = 7'h13;  1: opc = 7'h33;  2: opc = 7'h33;  3: opc = 7'h37;
      4: opc = 7'h17;  5: opc = 7'h6F;  6: opc = 7'h67;  7: opc = 7'h73;
      8: opc = 7'h03;  9: opc = 7'h23;  10: opc = 7'h63; 11: opc = 7'h0F;
      12: opc = 7'h3B; 13: opc = 7'h1B; 14: opc = 7'h01; default: opc = 7'h33;
    endcase
    if (opc == 7'h33) begin
      case ($urandom_range(0, 2))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        default: r[31:25] = 7'h01;
      endcase
    end
    return {r[31:7], opc};
  endfunction

  function automatic logic [31:0] addi(input int imm);
    return {12'(imm), 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  initial begin
    bund_t e;
    logic  exp_r, exp_v;

    tbl[0]  = '{32'h00500093, 32'h0,    32'h0,        32'h0, 32'h0,        32'h0,        32'h5,        RV_ALU_ADD,  1'b1, 8'h00, 1'b0};
    tbl[1]  = '{32'h402080B3, 32'h4,    32'h9,        32'h4, 32'h0,        32'h9,        32'h4,        RV_ALU_SUB,  1'b1, 8'h00, 1'b0};
    tbl[2]  = '{32'h123452B7, 32'h8,    32'h11111111, 32'h0, 32'h0,        32'h0,        32'h12345000, RV_ALU_ADD,  1'b1, 8'h00, 1'b0};
    tbl[3]  = '{32'h0220B0B3, 32'hC,    32'h7,        32'h3, 32'h0,        32'h7,        32'h3,        RV_ALU_NONE, 1'b1, 8'h08, 1'b0};
    tbl[4]  = '{32'hFFFFF197, 32'h1000, 32'h0,        32'h0, 32'h0,        32'h1000,     32'hFFFFF000, RV_ALU_ADD,  1'b1, 8'h00, 1'b0};
    tbl[5]  = '{32'h000000EF, 32'h200,  32'h0,        32'h0, 32'h0,        32'h200,      32'h4,        RV_ALU_ADD,  1'b1, 8'h00, 1'b0};
    tbl[6]  = '{32'h30002173, 32'h10,   32'h5,        32'h0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, RV_ALU_ADD,  1'b1, 8'h00, 1'b0};
    tbl[7]  = '{32'h00012083, 32'h14,   32'h100,      32'h0, 32'h0,        32'h0,        32'h0,        RV_ALU_NONE, 1'b1, 8'h00, 1'b0};
    tbl[8]  = '{32'h00112023, 32'h18,   32'h100,      32'h1, 32'h0,        32'h0,        32'h0,        RV_ALU_NONE, 1'b0, 8'h00, 1'b0};
    tbl[9]  = '{32'h00000001, 32'h1C,   32'h0,        32'h0, 32'h0,        32'h0,        32'h0,        RV_ALU_NONE, 1'b0, 8'h00, 1'b1};
    tbl[10] = '{32'h002080BB, 32'h20,   32'h1,        32'h2, 32'h0,        32'h0,        32'h0,        RV_ALU_NONE, 1'b0, 8'h00, 1'b1};
    tbl[11] = '{32'h4030D093, 32'h24,   32'h80000000, 32'h0, 32'h0,        32'h80000000, 32'h403,      RV_ALU_SRA,  1'b1, 8'h00, 1'b0};
    tbl[12] = '{32'hFFF0C093, 32'h28,   32'h0F0F0F0F, 32'h0, 32'h0,        32'h0F0F0F0F, 32'hFFFFFFFF, RV_ALU_XOR,  1'b1, 8'h00, 1'b0};
    tbl[13] = '{32'h00000073, 32'h2C,   32'h0,        32'h0, 32'h0,        32'h0,        32'h0,        RV_ALU_NONE, 1'b0, 8'h00, 1'b0};
    tbl[14] = '{32'h00208063, 32'h30,   32'h1,        32'h1, 32'h0,        32'h0,        32'h0,        RV_ALU_NONE, 1'b0, 8'h00, 1'b0};

    rst_n = 1'b0; flush = 1'b0; fvalid = 1'b0; busy = 1'b0; iready = 1'b1;
    instr = '0; pc = '0; rs1 = '0; rs2 = '0; csr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk1("reset_ready", frdy[0], 1'b1);
    chk1("reset_valid", ivalid[0], 1'b0);
    chkb("reset_outputs", got(0), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Decode table, issued back to back with issue_ready_i=1.
    for (int k = 0; k < 15; k++) begin
      instr = tbl[k].instr; pc = tbl[k].pc; rs1 = tbl[k].rs1; rs2 = tbl[k].rs2; csr = tbl[k].csr;
      fvalid = 1'b1;
      @(posedge clk); #1;
      e = '{pc: tbl[k].pc, a: tbl[k].a, b: tbl[k].b, func: tbl[k].func, wr: tbl[k].wr,
            rd: tbl[k].instr[11:7], md: tbl[k].md, inv: tbl[k].inv};
      $display("vec %0d instr=%08h a=%08h b=%08h func=%0d md=%02h inv=%b", k, instr, ao[0], bo[0], fn[0], md[0], inv[0]);
      chk1("vec_valid", ivalid[0], 1'b1);
      chkb("vec_bundle", got(0), e);
      if (tbl[k].md != 8'h00) begin
        e.a = '0; e.b = '0; e.wr = 1'b0; e.md = '0; e.inv = 1'b1;
        chkb("nomul_invalid", got(1), e);
      end
      if (tbl[k].inv) begin
        e.inv = 1'b0;
        chkb("notrap_invalid", got(2), e);
      end
    end
    fvalid = 1'b0;
    @(posedge clk); #1;
    chk1("vec_drained", ivalid[0], 1'b0);

    // Mul/div held while busy; plain ops ignore busy.
    instr = 32'h0220B0B3; fvalid = 1'b1; busy = 1'b1; iready = 1'b1;
    @(posedge clk); #1;
    fvalid = 1'b0;
    chk1("nomul_ignores_busy", ivalid[1], 1'b1);
    for (int j = 0; j < 3; j++) begin
      chk1("busy_hold", ivalid[0], 1'b0);
      @(posedge clk); #1;
    end
    busy = 1'b0; #1;
    chk1("busy_release", ivalid[0], 1'b1);
    chk1("busy_md", md[0] == 8'h08, 1'b1);
    @(posedge clk); #1;
    chk1("busy_done", ivalid[0], 1'b0);
    busy = 1'b1; instr = addi(3); fvalid = 1'b1;
    @(posedge clk); #1;
    fvalid = 1'b0;
    chk1("busy_plain_op", ivalid[0], 1'b1);
    @(posedge clk); #1;
    busy = 1'b0;

    // Three offers against a stalled output: two held, the third refused.
    iready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr = addi(i + 1); fvalid = 1'b1; #1;
      chk1("b2b_ready", frdy[0], i < 2);
      @(posedge clk); #1;
    end
    fvalid = 1'b0; iready = 1'b1; #1;
    chk1("b2b_first_valid", ivalid[0], 1'b1);
    chk1("b2b_first_b", bo[0] == 32'd1, 1'b1);
    @(posedge clk); #1;
    chk1("b2b_second_valid", ivalid[0], 1'b1);
    chk1("b2b_second_b", bo[0] == 32'd2, 1'b1);
    chk1("b2b_ready_back", frdy[0], 1'b1);
    @(posedge clk); #1;
    chk1("b2b_no_third", ivalid[0], 1'b0);

    // Flush with both entries full and a new offer.
    iready = 1'b0; fvalid = 1'b1; instr = addi(7);
    @(posedge clk); #1;
    instr = addi(8);
    @(posedge clk); #1;
    chk1("flush_full_ready", frdy[0], 1'b0);
    flush = 1'b1; instr = addi(9);
    @(posedge clk); #1;
    flush = 1'b0; fvalid = 1'b0;
    chk1("flush_valid", ivalid[0], 1'b0);
    chk1("flush_ready", frdy[0], 1'b1);
    @(posedge clk); #1;
    chk1("flush_stays_empty", ivalid[0], 1'b0);
    iready = 1'b1; fvalid = 1'b1; flush = 1'b1; instr = addi(10);
    @(posedge clk); #1;
    flush = 1'b0; fvalid = 1'b0;
    chk1("flush_drops_accept", ivalid[0], 1'b0);

    // Asynchronous reset in the middle of a stalled stream.
    iready = 1'b0; fvalid = 1'b1; instr = addi(11);
    @(posedge clk); #1;
    instr = addi(12);
    @(posedge clk); #1;
    fvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk1("midrst_ready", frdy[0], 1'b1);
    chk1("midrst_valid", ivalid[0], 1'b0);
    chkb("midrst_outputs", got(0), '0);
    @(posedge clk); #1;
    rst_n = 1'b1; iready = 1'b1;
    @(posedge clk); #1;
    chk1("midrst_no_issue", ivalid[0], 1'b0);

    // Randomized traffic against the queue model.
    for (int c = 0; c < 3000; c++) begin
      fvalid = ($urandom_range(0, 3) != 0);
      iready = ($urandom_range(0, 2) != 0);
      busy   = ($urandom_range(0, 3) == 0);
      flush  = ($urandom_range(0, 40) == 0);
      instr  = gen_instr();
      pc = $urandom(); rs1 = $urandom(); rs2 = $urandom(); csr = $urandom();
      #1;
      exp_r = (q.size() < 2);
      exp_v = (q.size() > 0) && !((q[0].md != 8'h00) && busy);
      chk1("rnd_ready", frdy[0], exp_r);
      chk1("rnd_valid", ivalid[0], exp_v);
      if (q.size() > 0) chkb("rnd_data", got(0), q[0]);
      @(posedge clk);
      if (flush) q.delete();
      else begin
        if (exp_v && iready) void'(q.pop_front());
        if (fvalid && exp_r) q.push_back(ref_dec(instr, pc, rs1, rs2, csr));
      end
      #1;
    end
    flush = 1'b0; fvalid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
